// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter that forwards bursts of words from N_SRC
// first-word-fall-through source FIFOs into one downstream FIFO.
// A grant lasts until the source runs dry, is disabled, or has moved
// MAX_BURST words; one idle arbitration cycle separates grants.
module stream_rr_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                        BUS_CLK,
  input  logic                        BUS_RST,
  input  logic [N_SRC-1:0]            SRC_ENABLE,
  input  logic [N_SRC-1:0]            SRC_EMPTY,
  input  logic [N_SRC*DATA_WIDTH-1:0] SRC_DATA,
  output logic [N_SRC-1:0]            SRC_READ,
  input  logic                        OUT_READY,
  output logic                        OUT_WRITE,
  output logic [DATA_WIDTH-1:0]       OUT_DATA,
  output logic [N_SRC-1:0]            GRANT,
  input  logic                        CNT_CLEAR,
  output logic [31:0]                 WORD_CNT
);

  localparam int IDX_W = $clog2(N_SRC);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [7:0]       burst_q, burst_d;
  logic [31:0]      word_cnt_q, word_cnt_d;

  logic [N_SRC-1:0]      request_s;
  logic                  pick_valid_s;
  logic [IDX_W-1:0]      pick_idx_s;
  logic [N_SRC-1:0]      grant_s;
  logic [N_SRC-1:0]      src_read_s;
  logic                  out_write_s;
  logic [DATA_WIDTH-1:0] out_data_s;
  logic                  xfer_s;
  logic                  req_g_s;

  assign request_s = SRC_ENABLE & ~SRC_EMPTY;

  // Circular search for the first requester after the last granted source.
  always_comb begin
    int cand;
    pick_valid_s = 1'b0;
    pick_idx_s   = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = int'(last_q) + k;
      if (cand >= N_SRC) begin
        cand = cand - N_SRC;
      end else begin
        cand = cand;
      end
      if (!pick_valid_s && request_s[cand]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = IDX_W'(cand);
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  // Next-state logic and datapath steering for the IDLE/GRANT machine.
  always_comb begin
    state_d     = state_q;
    gnt_idx_d   = gnt_idx_q;
    last_d      = last_q;
    burst_d     = burst_q;
    grant_s     = '0;
    src_read_s  = '0;
    out_write_s = 1'b0;
    out_data_s  = '0;
    xfer_s      = 1'b0;
    req_g_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid_s) begin
          state_d   = S_GRANT;
          gnt_idx_d = pick_idx_s;
          burst_d   = 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        req_g_s              = request_s[gnt_idx_q];
        grant_s[gnt_idx_q]   = 1'b1;
        out_write_s          = req_g_s;
        if (req_g_s) begin
          out_data_s = SRC_DATA[gnt_idx_q*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          out_data_s = '0;
        end
        xfer_s                = req_g_s & OUT_READY;
        src_read_s[gnt_idx_q] = xfer_s;
        if (!req_g_s) begin
          // Source ran dry or was disabled: release the bus.
          state_d = S_IDLE;
          last_d  = gnt_idx_q;
          burst_d = 8'd0;
        end else if (xfer_s) begin
          if (burst_q + 8'd1 == 8'(MAX_BURST)) begin
            state_d = S_IDLE;
            last_d  = gnt_idx_q;
            burst_d = 8'd0;
          end else begin
            burst_d = burst_q + 8'd1;
          end
        end else begin
          // Downstream stall: hold grant and burst count indefinitely.
          burst_d = burst_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Saturating forwarded-word counter; clear wins over a same-cycle transfer.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (CNT_CLEAR) begin
      word_cnt_d = 32'd0;
    end else if (xfer_s && (word_cnt_q != 32'hFFFF_FFFF)) begin
      word_cnt_d = word_cnt_q + 32'd1;
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  // State registers with synchronous reset; LAST starts at N_SRC-1 so source 0 wins first.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q    <= S_IDLE;
      gnt_idx_q  <= '0;
      last_q     <= IDX_W'(N_SRC - 1);
      burst_q    <= 8'd0;
      word_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Combinational outputs are forced quiet during the reset cycle so an
  // aborted burst never pops a source.
  assign GRANT     = BUS_RST ? '0   : grant_s;
  assign SRC_READ  = BUS_RST ? '0   : src_read_s;
  assign OUT_WRITE = BUS_RST ? 1'b0 : out_write_s;
  assign OUT_DATA  = BUS_RST ? '0   : out_data_s;
  assign WORD_CNT  = word_cnt_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: source FIFOs are modelled with
// queues, expected words (source + data) are queued as stimulus is planned
// and popped whenever the DUT pops a source.
module tb_stream_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  ena, empty, src_read, grant;
  logic [N*DW-1:0] sdata;
  logic          ready, owrite, cnt_clear;
  logic [DW-1:0] odata;
  logic [31:0]   wcnt;

  always #5 clk = ~clk;

  stream_rr_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .BUS_CLK(clk), .BUS_RST(rst), .SRC_ENABLE(ena), .SRC_EMPTY(empty),
    .SRC_DATA(sdata), .SRC_READ(src_read), .OUT_READY(ready),
    .OUT_WRITE(owrite), .OUT_DATA(odata), .GRANT(grant),
    .CNT_CLEAR(cnt_clear), .WORD_CNT(wcnt)
  );

  typedef struct packed {
    logic [7:0]  src;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          exp_burst[$];
  logic [31:0] src_q [N][$];

  int vec_cnt = 0;
  int err_cnt = 0;
  bit gap_chk = 1'b0;
  bit seen_grant = 1'b0;
  int zero_run = 0;
  int cur_burst = 0;
  logic [N-1:0] prev_grant = '0;
  logic [N-1:0] smp_grant, smp_read;
  logic         smp_owrite;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic update_src();
    for (int i = 0; i < N; i++) begin
      empty[i] = (src_q[i].size() == 0);
      sdata[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0] : 32'd0;
    end
  endtask

  task automatic push_src(input int s, input int base, input int n);
    for (int k = 0; k < n; k++) src_q[s].push_back((32'(s) << 24) | 32'(base + k));
  endtask

  task automatic push_exp(input int s, input int base, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.src  = 8'(s);
      e.data = (32'(s) << 24) | 32'(base + k);
      exp_q.push_back(e);
    end
  endtask

  // One clock: sample and check at the falling edge, pop model FIFOs after the rising edge.
  task automatic tick();
    logic [N-1:0] req, want_read;
    exp_t e;
    @(negedge clk);
    req = ena & ~empty;
    want_read = (rst || !ready) ? 4'b0000 : (grant & req);
    smp_grant = grant; smp_read = src_read; smp_owrite = owrite;
    chk("src_read", 64'(src_read), 64'(want_read));
    chk("out_write", 64'(owrite), 64'(!rst && ((grant & req) != 4'b0000)));
    if (grant != 4'b0000) begin
      if (prev_grant != 4'b0000) chk("grant_hold", 64'(grant), 64'(prev_grant));
      else if (seen_grant && gap_chk) chk("idle_gap", 64'(zero_run), 64'd1);
      seen_grant = 1'b1;
      zero_run = 0;
    end else begin
      zero_run++;
      if (prev_grant != 4'b0000) begin
        if (exp_burst.size() != 0) chk("burst_len", 64'(cur_burst), 64'(exp_burst.pop_front()));
        cur_burst = 0;
      end
    end
    prev_grant = grant;
    for (int i = 0; i < N; i++) begin
      if (src_read[i]) begin
        cur_burst++;
        if (exp_q.size() == 0) begin
          chk("unexpected_read", 64'(src_read), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("grant_src", 64'(grant), 64'(4'b0001 << e.src));
          chk("out_data", 64'(odata), 64'(e.data));
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (smp_read[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    end
    update_src();
  endtask

  task automatic drain(input int budget, output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      tick();
      cyc++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    exp_burst.delete();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cur_burst = 0;
    seen_grant = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 1'b1; ena = 4'b1111; ready = 1'b1; cnt_clear = 1'b0;
    update_src();
    do_reset();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_read", 64'(src_read), 64'd0);
    chk("rst_write", 64'(owrite), 64'd0);
    chk("rst_data", 64'(odata), 64'd0);
    chk("rst_wcnt", 64'(wcnt), 64'd0);

    // Single source, three words: one idle cycle then three back-to-back transfers.
    push_src(0, 0, 3); push_exp(0, 0, 3); update_src();
    drain(20, cyc);
    chk("s033_cycles", 64'(cyc), 64'd4);
    tick(); tick();
    chk("s033_idle", 64'(grant), 64'd0);
    chk("s033_wcnt", 64'(wcnt), 64'd3);

    // Three sources with 40 words each: rotating 16-word bursts then 8-word tails.
    do_reset();
    gap_chk = 1'b1;
    for (int s = 0; s < 3; s++) push_src(s, 0, 40);
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < 3; s++) begin
        push_exp(s, r * 16, (r < 2) ? 16 : 8);
        exp_burst.push_back((r < 2) ? 16 : 8);
      end
    update_src();
    drain(400, cyc);
    tick(); tick(); tick();
    chk("s034_bursts_left", 64'(exp_burst.size()), 64'd0);
    chk("s034_wcnt", 64'(wcnt), 64'd120);

    // Source 1 alone under a 1,0,1,0 ready pattern: bursts count only ready cycles.
    do_reset();
    push_src(1, 0, 20); push_exp(1, 0, 20);
    exp_burst.push_back(16); exp_burst.push_back(4);
    update_src();
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      ready = (cyc % 2 == 0);
      tick();
      cyc++;
    end
    chk("s035_done", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    ready = 1'b1;
    tick(); tick(); tick();
    chk("s035_bursts_left", 64'(exp_burst.size()), 64'd0);
    chk("s035_wcnt", 64'(wcnt), 64'd20);
    gap_chk = 1'b0;

    // Disable source 2 mid-burst: no transfer that cycle, next grant is source 3.
    do_reset();
    push_src(2, 0, 10); push_exp(2, 0, 3); update_src();
    drain(20, cyc);
    ena[2] = 1'b0;
    push_src(3, 0, 5); push_src(0, 0, 5); update_src();
    push_exp(3, 0, 5); push_exp(0, 0, 5);
    tick();
    chk("s036_grant", 64'(smp_grant), 64'(4'b0100));
    chk("s036_write", 64'(smp_owrite), 64'd0);
    chk("s036_read", 64'(smp_read), 64'd0);
    drain(60, cyc);
    ena[2] = 1'b1; update_src();
    push_exp(2, 3, 7);
    drain(60, cyc);
    tick(); tick();
    chk("s036_wcnt", 64'(wcnt), 64'd20);

    // Saturation from a preloaded count, then clear racing a transfer.
    do_reset();
    force dut.word_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.word_cnt_q;
    push_src(0, 0, 5); push_exp(0, 0, 5); update_src();
    drain(20, cyc);
    tick(); tick();
    chk("s037_sat", 64'(wcnt), 64'hFFFF_FFFF);
    push_src(0, 5, 3); push_exp(0, 5, 3); update_src();
    tick();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("s037_clear", 64'(wcnt), 64'd0);
    drain(20, cyc);
    chk("s037_after", 64'(wcnt), 64'd2);
    tick(); tick();

    // Reset pulse in the middle of a source-1 burst.
    do_reset();
    push_src(1, 0, 10); push_exp(1, 0, 2); update_src();
    drain(20, cyc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s038_read", 64'(smp_read), 64'd0);
    chk("s038_grant", 64'(smp_grant), 64'd0);
    chk("s038_write", 64'(smp_owrite), 64'd0);
    push_src(0, 0, 3); update_src();
    push_exp(0, 0, 3); push_exp(1, 2, 8);
    drain(60, cyc);
    tick(); tick();
    chk("s038_wcnt", 64'(wcnt), 64'd11);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
